// File: rtl/pio_timer_ctr_pkg.sv
// Shared constants and types for the three-channel PIO timer.
package pio_timer_pkg;

  localparam int NCH = 3;

  // counter_set decode
  localparam logic [1:0] CS_CH0  = 2'b00;
  localparam logic [1:0] CS_CH1  = 2'b01;
  localparam logic [1:0] CS_CH2  = 2'b10;
  localparam logic [1:0] CS_CTRL = 2'b11;

  // Control-word bit positions
  localparam int EN_LSB       = 0;
  localparam int MODE_LSB     = 3;
  localparam int MASK_LSB     = 6;
  localparam int PSC_CLR_BIT  = 30;
  localparam int STAT_CLR_BIT = 31;

  // Packed in readback order: {irq_mask, mode, en} = bits 8:0
  typedef struct packed {
    logic [NCH-1:0] irq_mask;
    logic [NCH-1:0] mode;
    logic [NCH-1:0] en;
  } ctrl_t;

  function automatic ctrl_t ctrl_from_wdata(input logic [31:0] wd);
    ctrl_t c;
    c.en       = wd[EN_LSB   +: NCH];
    c.mode     = wd[MODE_LSB +: NCH];
    c.irq_mask = wd[MASK_LSB +: NCH];
    return c;
  endfunction

endpackage

// File: rtl/pio_timer_ctr_if.sv
// CPU-side bus of the timer: write strobe, selector, data and timer outputs.
interface pio_timer_ctr_if;
  logic        we;
  logic [1:0]  counter_set;
  logic [31:0] wdata;
  logic [2:0]  ctr_out;
  logic        irq;
  logic [31:0] rdata;

  modport master (output we, counter_set, wdata, input ctr_out, irq, rdata);
  modport slave  (input we, counter_set, wdata, output ctr_out, irq, rdata);
endinterface

// File: rtl/pio_timer_ctr_channel.sv
// One timer channel: count/reload registers, expiry detection and ctr_out.
// Auto-reload with reload >= 2 loads reload at the expiry edge, so the
// period is exactly reload ticks; otherwise the channel behaves one-shot.
module timer_channel #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             ctr_out,
  output logic             expire
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] reload_q;
  logic             out_q;
  logic             periodic;

  assign periodic = mode && (reload_q > CNT_W'(1));
  // A load on the same edge suppresses the expiry entirely.
  assign expire   = tick && en && (count_q == CNT_W'(1)) && !load;

  // Count/reload update and expiry output register.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      count_q  <= '0;
      reload_q <= '0;
      out_q    <= 1'b0;
    end else if (load) begin
      count_q  <= load_val;
      reload_q <= load_val;
      out_q    <= 1'b0;
    end else begin
      if (tick && en && (count_q != '0)) begin
        if ((count_q == CNT_W'(1)) && periodic) count_q <= reload_q;
        else                                    count_q <= count_q - CNT_W'(1);
      end
      if (expire)        out_q <= 1'b1;
      else if (periodic) out_q <= 1'b0;
    end
  end

  assign count   = count_q;
  assign ctr_out = out_q;

endmodule

// File: rtl/pio_timer_ctr.sv
// Three-channel programmable down-counter/timer with sticky status and irq.
// Optional prescaler enabled by defining TIMER_PRESCALE_EN.
module pio_timer_ctr
  import pio_timer_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int PRESCALE_DIV = 16
) (
  input logic              clk,
  input logic              rst,
  pio_timer_ctr_if.slave   bus
);

  if (PRESCALE_DIV < 2) begin : g_div_check
    $error("PRESCALE_DIV must be >= 2");
  end

  ctrl_t            ctrl_q;
  logic [NCH-1:0]   status_q;
  logic             irq_q;
  logic             tick;
  logic             ctrl_wr;
  logic             stat_clr;
  logic [NCH-1:0]   load_vec;
  logic [NCH-1:0]   expire_vec;
  logic [NCH-1:0]   out_vec;
  logic [CNT_W-1:0] count_arr [NCH];
  logic             unused_wdata;

  assign ctrl_wr  = bus.we && (bus.counter_set == CS_CTRL);
  assign stat_clr = ctrl_wr && bus.wdata[STAT_CLR_BIT];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign load_vec[i] = bus.we && (bus.counter_set == 2'(i));

    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .en       (ctrl_q.en[i]),
      .mode     (ctrl_q.mode[i]),
      .load     (load_vec[i]),
      .load_val (bus.wdata[CNT_W-1:0]),
      .count    (count_arr[i]),
      .ctr_out  (out_vec[i]),
      .expire   (expire_vec[i])
    );
  end

`ifdef TIMER_PRESCALE_EN
  localparam int PSC_W = $clog2(PRESCALE_DIV);
  logic [PSC_W-1:0] psc_q;

  assign tick = (psc_q == PSC_W'(PRESCALE_DIV - 1));

  // Free-running prescaler, restartable from a control write.
  always_ff @(posedge clk) begin
    if (rst || (ctrl_wr && bus.wdata[PSC_CLR_BIT])) psc_q <= '0;
    else if (tick)                                  psc_q <= '0;
    else                                            psc_q <= psc_q + PSC_W'(1);
  end

  assign unused_wdata = ^bus.wdata[29:9];
`else
  assign tick         = 1'b1;
  assign unused_wdata = ^{bus.wdata[PSC_CLR_BIT], bus.wdata[29:9]};
`endif

  // Control register: written as a whole on any control write.
  always_ff @(posedge clk) begin
    if (rst)          ctrl_q <= '0;
    else if (ctrl_wr) ctrl_q <= ctrl_from_wdata(bus.wdata);
  end

  // Sticky status: set on expiry, cleared by channel load or bulk clear.
  always_ff @(posedge clk) begin
    if (rst)           status_q <= '0;
    else if (stat_clr) status_q <= '0;
    else               status_q <= (status_q & ~load_vec) | expire_vec;
  end

  // Registered interrupt, one cycle behind status/mask.
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= |(status_q & ctrl_q.irq_mask);
  end

  // Readback mux, selected by counter_set only.
  always_comb begin
    // NOTE: default assigned first so no path leaves rdata unassigned (no latch).
    bus.rdata = '0;
    case (bus.counter_set)
      CS_CH0:  bus.rdata[CNT_W-1:0] = count_arr[0];
      CS_CH1:  bus.rdata[CNT_W-1:0] = count_arr[1];
      CS_CH2:  bus.rdata[CNT_W-1:0] = count_arr[2];
      CS_CTRL: begin
        bus.rdata[31:29] = status_q;
        bus.rdata[8:0]   = ctrl_q;
      end
      default: bus.rdata = '0;
    endcase
  end

  assign bus.ctr_out = out_vec;
  assign bus.irq     = irq_q;

endmodule

// File: tb/tb_pio_timer_ctr.sv
// Scoreboard bench for pio_timer_ctr: a behavioural model predicts outputs
// per cycle into a queue; a separate monitor compares them after each edge.
module tb_pio_timer_ctr;

  localparam int TB_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pio_timer_ctr_if bus();

  pio_timer_ctr #(.CNT_W(32), .PRESCALE_DIV(TB_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  ctr_out;
    logic        irq;
    logic [31:0] rdata;
  } obs_t;

  obs_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   stim_done = 1'b0;

  // Reference model state
  logic [31:0] m_cnt [3];
  logic [31:0] m_rel [3];
  logic [2:0]  m_out, m_status, m_en, m_mode, m_mask;
  logic        m_irq;
  int          m_psc;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = '0;
      m_rel[i] = '0;
    end
    m_out = '0; m_status = '0; m_en = '0; m_mode = '0; m_mask = '0;
    m_irq = 1'b0;
    m_psc = 0;
  endtask

  // Behaviour of one clock edge, expressed as the timer's rules.
  task automatic model_edge(input bit r, input bit w, input logic [1:0] cs, input logic [31:0] wd);
    bit   tick_now;
    bit   periodic;
    logic irq_next;
    if (r) begin
      model_reset();
      return;
    end
`ifdef TIMER_PRESCALE_EN
    tick_now = (m_psc == TB_DIV - 1);
`else
    tick_now = 1'b1;
`endif
    irq_next = |(m_status & m_mask);
    for (int i = 0; i < 3; i++) begin
      periodic = m_mode[i] && (m_rel[i] >= 2);
      if (w && cs == 2'(i)) begin
        m_cnt[i] = wd; m_rel[i] = wd; m_out[i] = 1'b0; m_status[i] = 1'b0;
      end else if (tick_now && m_en[i] && m_cnt[i] == 1) begin
        m_cnt[i] = periodic ? m_rel[i] : 32'd0;
        m_out[i] = 1'b1;
        m_status[i] = 1'b1;
      end else begin
        if (tick_now && m_en[i] && m_cnt[i] != 0) m_cnt[i] = m_cnt[i] - 1;
        if (periodic) m_out[i] = 1'b0;
      end
    end
    if (w && cs == 2'b11) begin
      if (wd[31]) m_status = '0;
      m_en = wd[2:0]; m_mode = wd[5:3]; m_mask = wd[8:6];
    end
`ifdef TIMER_PRESCALE_EN
    if (w && cs == 2'b11 && wd[30]) m_psc = 0;
    else                            m_psc = (m_psc + 1) % TB_DIV;
`endif
    m_irq = irq_next;
  endtask

  function automatic logic [31:0] model_rdata(input logic [1:0] cs);
    if (cs == 2'b11) return {m_status, 20'b0, m_mask, m_mode, m_en};
    return m_cnt[cs];
  endfunction

  // Drive one cycle of inputs and queue the expected post-edge outputs.
  task automatic cycle(input bit r, input bit w, input logic [1:0] cs, input logic [31:0] wd);
    obs_t e;
    @(negedge clk);
    rst = r; bus.we = w; bus.counter_set = cs; bus.wdata = wd;
    model_edge(r, w, cs, wd);
    e.ctr_out = m_out;
    e.irq     = m_irq;
    e.rdata   = model_rdata(cs);
    exp_q.push_back(e);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 2'($urandom_range(0, 3)), $urandom);
  endtask

  task automatic stimulus();
    int k;
    logic [31:0] wd;
    logic [1:0]  cs;
    // Reset, reading every selector
    for (int c = 0; c < 4; c++) cycle(1'b1, 1'b0, 2'(c), 32'h0);
    // One-shot ch0 = 5
    cycle(1'b0, 1'b1, 2'b00, 32'd5);
    cycle(1'b0, 1'b1, 2'b11, 32'h001);
    repeat (30) idle();
    // Auto-reload ch1 = 4
    cycle(1'b0, 1'b1, 2'b01, 32'd4);
    cycle(1'b0, 1'b1, 2'b11, 32'h012);
    repeat (40) idle();
    // Collision: reload ch2 on its expiry edge
    cycle(1'b0, 1'b1, 2'b11, 32'h004);
    cycle(1'b0, 1'b1, 2'b10, 32'd3);
    k = 0;
    while (m_cnt[2] != 1 && k < 64) begin idle(); k++; end
    cycle(1'b0, 1'b1, 2'b10, 32'd10);
    repeat (3) cycle(1'b0, 1'b0, 2'b11, 32'h0);
    repeat (4) cycle(1'b0, 1'b0, 2'b10, 32'h0);
    // IRQ: ch0 one-shot 3, mask ch0, then bulk clear
    cycle(1'b0, 1'b1, 2'b00, 32'd3);
    cycle(1'b0, 1'b1, 2'b11, 32'h041);
    repeat (20) idle();
    cycle(1'b0, 1'b1, 2'b11, 32'h8000_0041);
    repeat (3) idle();
    // Freeze and resume mid-count
    cycle(1'b0, 1'b1, 2'b00, 32'd9);
    cycle(1'b0, 1'b1, 2'b11, 32'h001);
    repeat (5) idle();
    cycle(1'b0, 1'b1, 2'b11, 32'h000);
    repeat (6) cycle(1'b0, 1'b0, 2'b00, 32'h0);
    cycle(1'b0, 1'b1, 2'b11, 32'h001);
    repeat (40) idle();
    // Load 0 and reload 1 under auto-reload
    cycle(1'b0, 1'b1, 2'b01, 32'd0);
    cycle(1'b0, 1'b1, 2'b10, 32'd1);
    cycle(1'b0, 1'b1, 2'b11, 32'h1FF);
    repeat (12) idle();
    // Reset mid-count
    cycle(1'b0, 1'b1, 2'b00, 32'd6);
    repeat (2) idle();
    cycle(1'b1, 1'b0, 2'b00, 32'h0);
    repeat (4) idle();
    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      cs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) begin
        cycle(1'b1, 1'b0, cs, $urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        if (cs == 2'b11) begin
          wd = $urandom & 32'h0000_01FF;
          if ($urandom_range(0, 7) == 0) wd[31] = 1'b1;
          if ($urandom_range(0, 3) == 0) wd[30] = 1'b1;
        end else begin
          wd = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, 12));
        end
        cycle(1'b0, 1'b1, cs, wd);
      end else begin
        cycle(1'b0, 1'b0, cs, $urandom);
      end
    end
    stim_done = 1'b1;
  endtask

  task automatic monitor();
    obs_t e;
    int   budget = 0;
    while (!(stim_done && exp_q.size() == 0)) begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (bus.ctr_out !== e.ctr_out || bus.irq !== e.irq || bus.rdata !== e.rdata) begin
          n_miss++;
          $display("FAIL vec%0d t=%0t: got ctr_out=%b irq=%b rdata=%h, expected ctr_out=%b irq=%b rdata=%h",
                   n_vec, $time, bus.ctr_out, bus.irq, bus.rdata, e.ctr_out, e.irq, e.rdata);
        end
      end
      budget++;
      if (budget > 20000) begin
        n_miss++;
        $display("FAIL monitor_timeout: %0d entries pending, expected 0", exp_q.size());
        break;
      end
    end
  endtask

  initial begin
    bus.we = 1'b0;
    bus.counter_set = 2'b00;
    bus.wdata = 32'h0;
    model_reset();
    fork
      stimulus();
      monitor();
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
